// File: rtl/soc_pkg.sv
// soc_pkg: shared RV32I encodings, memory map constants and ALU helpers
package soc_pkg;
  localparam int ROM_WORDS = 4096;
  localparam int RAM_WORDS = 16;
  localparam logic [31:0] RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_B    = 3'd0;
  localparam logic [2:0] F3_H    = 3'd1;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [31:0] alu_f(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction
endpackage

// File: rtl/soc_if.sv
// soc_if: data bus between the core and a memory, byte-enabled write, comb read
interface soc_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        we;
  modport master(output addr, wdata, be, we, input rdata);
  modport slave(input addr, wdata, be, we, output rdata);
endinterface

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I datapath with regfile and PC, drives the data bus
module rv32i_core import soc_pkg::*; (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] fetch_data,
  output logic [31:0] pc,
  output logic [31:0] ir,
  soc_if.master       dbus
);
  logic [31:0] rf [0:31];
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, a, b, alu_y, addr, lane, ld_val, wb, pc_next;
  logic [15:0] half;
  logic        alt, taken, rd_we;
  assign ir = fetch_data;
  assign opc = ir[6:0];
  assign rd = ir[11:7];
  assign f3 = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign a = rs1 == 5'd0 ? '0 : rf[rs1];
  assign b = rs2 == 5'd0 ? '0 : rf[rs2];
  always_comb begin
    alt = ir[30] & (f3 == F3_SR | (opc == OP_REG & f3 == F3_ADD));
    alu_y = alu_f(alu_sel(f3, alt), a, opc == OP_REG ? b : imm_i);
    addr = a + (opc == OP_ST ? imm_s : imm_i);
    lane = dbus.rdata >> {addr[1:0], 3'b000};
    half = addr[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    ld_val = f3[1:0] == 2'd0 ? {{24{~f3[2] & lane[7]}}, lane[7:0]} :
             f3[1:0] == 2'd1 ? {{16{~f3[2] & half[15]}}, half} : dbus.rdata;
    // funct3[2] picks the compare kind, funct3[0] inverts it
    taken = (f3[2] ? (f3[1] ? a < b : $signed(a) < $signed(b)) : a == b) ^ f3[0];
    pc_next = opc == OP_JAL ? pc + imm_j :
              opc == OP_JALR ? (a + imm_i) & ~32'd1 :
              (opc == OP_BR && taken) ? pc + imm_b : pc + 32'd4;
    rd_we = rd != 5'd0 && opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG};
    wb = opc == OP_LUI ? imm_u :
         opc == OP_AUIPC ? pc + imm_u :
         (opc == OP_JAL || opc == OP_JALR) ? pc + 32'd4 :
         opc == OP_LD ? ld_val : alu_y;
  end
  assign dbus.addr = addr;
  assign dbus.we = opc == OP_ST && rstn;
  assign dbus.be = f3 == F3_B ? 4'b0001 << addr[1:0] : f3 == F3_H ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dbus.wdata = f3 == F3_B ? {4{b[7:0]}} : f3 == F3_H ? {2{b[15:0]}} : b;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (rd_we) rf[rd] <= wb;
    end
endmodule

// File: rtl/soc_ram.sv
// soc_ram: small control RAM, comb read, sync byte write, async clear
module soc_ram import soc_pkg::*; (
  input  logic clk,
  input  logic rstn,
  soc_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [0:RAM_WORDS-1];
  assign bus.rdata = ram[bus.addr[AW+1:2]];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
    else
      for (int i = 0; i < 4; i++)
        if (bus.we && bus.be[i]) ram[bus.addr[AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
endmodule

// File: rtl/soc_rom.sv
// soc_rom: unified code/data memory, comb fetch and data read, sync byte write, never reset
module soc_rom import soc_pkg::*; (
  input  logic        clk,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  soc_if.slave        bus
);
  localparam int AW = $clog2(ROM_WORDS);
  logic [31:0] rom [0:ROM_WORDS-1];
  assign fetch_data = rom[fetch_addr[AW+1:2]];
  assign bus.rdata = rom[bus.addr[AW+1:2]];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (bus.we && bus.be[i]) rom[bus.addr[AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
endmodule

// File: rtl/soc.sv
// soc: single-cycle RV32I system with unified code/data ROM and a small control RAM
module soc import soc_pkg::*; (
  input logic clk,
  input logic rstn
);
  logic [31:0] PC, IR, rom_ir;
  logic        ram_sel;
  soc_if dbus();
  soc_if rom_bus();
  soc_if ram_bus();
  rv32i_core u_core (.clk(clk), .rstn(rstn), .fetch_data(rom_ir), .pc(PC), .ir(IR), .dbus(dbus));
  soc_rom u_rom (.clk(clk), .fetch_addr(PC), .fetch_data(rom_ir), .bus(rom_bus));
  soc_ram u_ram (.clk(clk), .rstn(rstn), .bus(ram_bus));
  assign ram_sel = dbus.addr[31:28] == RAM_BASE[31:28];
  assign rom_bus.addr = dbus.addr;
  assign rom_bus.wdata = dbus.wdata;
  assign rom_bus.be = dbus.be;
  assign rom_bus.we = dbus.we & ~ram_sel;
  assign ram_bus.addr = dbus.addr;
  assign ram_bus.wdata = dbus.wdata;
  assign ram_bus.be = dbus.be;
  assign ram_bus.we = dbus.we & ram_sel;
  assign dbus.rdata = ram_sel ? ram_bus.rdata : rom_bus.rdata;
endmodule

// File: tb/tb_soc.sv
// tb_soc: directed RV32I program with hand-computed results read back from memory
module tb_soc;
  logic clk = 0;
  logic rstn = 1;
  int n_cmp = 0;
  int n_bad = 0;
  logic done;
  soc dut (.clk(clk), .rstn(rstn));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] f3, input logic [31:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [31:0] rs2, input logic [31:0] rs1, input logic [31:0] f3, input logic [31:0] rd);
    return {f7, rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2, input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2, input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [31:0] rd, input logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  task automatic put(input int byte_addr, input logic [31:0] w);
    dut.u_rom.rom[byte_addr/4] = w;
  endtask
  localparam logic [6:0] I_OP = 7'b0010011, I_LD = 7'b0000011, I_JALR = 7'b1100111;
  localparam logic [6:0] I_LUI = 7'b0110111, I_AUIPC = 7'b0010111;
  logic [31:0] first_word;
  initial begin
    #1 rstn = 0;
    for (int i = 0; i < 4096; i++) dut.u_rom.rom[i] = '0;
    put('h00, enc_i(-1, 0, 0, 1, I_OP));
    put('h04, enc_i(28, 1, 5, 2, I_OP));
    put('h08, enc_i('h400 | 28, 1, 5, 3, I_OP));
    put('h0C, enc_r(7'h00, 1, 0, 3, 4));
    put('h10, enc_b(8, 0, 1, 4));
    put('h14, enc_i(1, 0, 0, 10, I_OP));
    put('h18, enc_b(8, 0, 1, 6));
    put('h1C, enc_i(1, 0, 0, 11, I_OP));
    put('h20, enc_j(8, 1));
    put('h24, enc_i(1, 0, 0, 12, I_OP));
    put('h28, enc_i('h40, 0, 0, 5, I_OP));
    put('h2C, enc_i(1, 5, 0, 0, I_JALR));
    put('h30, enc_i(1, 0, 0, 13, I_OP));
    put('h40, enc_i(5, 0, 0, 0, I_OP));
    put('h44, enc_r(7'h00, 0, 0, 0, 6));
    put('h48, enc_u('h11223, 7, I_LUI));
    put('h4C, enc_i('h344, 7, 0, 7, I_OP));
    put('h50, enc_s('h100, 7, 0, 2));
    put('h54, enc_i('h103, 0, 0, 8, I_LD));
    put('h58, enc_i('h102, 0, 1, 9, I_LD));
    put('h5C, enc_i('h80, 0, 0, 14, I_OP));
    put('h60, enc_s('h101, 14, 0, 0));
    put('h64, enc_i('h101, 0, 0, 15, I_LD));
    put('h68, enc_i('h101, 0, 4, 16, I_LD));
    put('h6C, enc_s('h200, 2, 0, 2));
    put('h70, enc_s('h204, 3, 0, 2));
    put('h74, enc_s('h208, 4, 0, 2));
    put('h78, enc_s('h20C, 6, 0, 2));
    put('h7C, enc_s('h180, 1, 0, 2));
    put('h80, enc_s('h184, 8, 0, 2));
    put('h84, enc_s('h188, 9, 0, 2));
    put('h88, enc_s('h18C, 15, 0, 2));
    put('h8C, enc_s('h190, 16, 0, 2));
    put('h90, enc_s('h194, 10, 0, 2));
    put('h94, enc_s('h198, 11, 0, 2));
    put('h98, enc_s('h19C, 12, 0, 2));
    put('h9C, enc_s('h1A0, 13, 0, 2));
    put('hA0, enc_u(1, 18, I_AUIPC));
    put('hA4, enc_s('h1A4, 18, 0, 2));
    put('hA8, enc_r(7'h20, 7, 4, 0, 19));
    put('hAC, enc_s('h1A8, 19, 0, 2));
    put('hB0, enc_u('h10000, 20, I_LUI));
    put('hB4, enc_i('h200, 0, 0, 21, I_OP));
    put('hB8, enc_s(8, 21, 20, 2));
    put('hBC, enc_i('h210, 0, 0, 21, I_OP));
    put('hC0, enc_s(12, 21, 20, 2));
    put('hC4, enc_i(8, 20, 2, 22, I_LD));
    put('hC8, enc_s('h1AC, 22, 0, 2));
    put('hCC, enc_i(1, 0, 0, 21, I_OP));
    put('hD0, enc_s(16, 21, 20, 2));
    put('hD4, enc_j(0, 0));
    first_word = enc_i(-1, 0, 0, 1, I_OP);
    #1000;
    check("reset_pc", dut.PC, 32'h0);
    check("reset_ir", dut.IR, first_word);
    for (int i = 0; i < 16; i++) check($sformatf("reset_ram%0d", i), dut.u_ram.ram[i], 32'h0);
    @(negedge clk) rstn = 1;
    done = 0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = dut.u_ram.ram[4] == 32'd1;
    end
    check("done_flag", {31'b0, done}, 32'd1);
    check("sig_srli", dut.u_rom.rom['h80], 32'h0000000F);
    check("sig_srai", dut.u_rom.rom['h81], 32'hFFFFFFFF);
    check("sig_sltu", dut.u_rom.rom['h82], 32'h00000001);
    check("sig_x0", dut.u_rom.rom['h83], 32'h00000000);
    check("jal_link", dut.u_rom.rom['h60], 32'h00000024);
    check("lb_103", dut.u_rom.rom['h61], 32'h00000011);
    check("lh_102", dut.u_rom.rom['h62], 32'h00001122);
    check("lb_101", dut.u_rom.rom['h63], 32'hFFFFFF80);
    check("lbu_101", dut.u_rom.rom['h64], 32'h00000080);
    check("blt_taken", dut.u_rom.rom['h65], 32'h0);
    check("bltu_not", dut.u_rom.rom['h66], 32'h1);
    check("jal_skip", dut.u_rom.rom['h67], 32'h0);
    check("jalr_skip", dut.u_rom.rom['h68], 32'h0);
    check("auipc", dut.u_rom.rom['h69], 32'h000010A0);
    check("sub", dut.u_rom.rom['h6A], 32'hEEDDCCBD);
    check("ram_lw", dut.u_rom.rom['h6B], 32'h00000200);
    check("mem_word", dut.u_rom.rom['h40], 32'h11228044);
    check("ram2", dut.u_ram.ram[2], 32'h00000200);
    check("ram3", dut.u_ram.ram[3], 32'h00000210);
    check("ram4", dut.u_ram.ram[4], 32'h00000001);
    check("loop_pc", dut.PC, 32'h000000D4);
    #2 rstn = 0;
    #1;
    check("async_pc", dut.PC, 32'h0);
    check("async_ram4", dut.u_ram.ram[4], 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
